// File: rtl/mux8x1_rr_sched_if.sv
// Request/grant bundle between the requesters, the round-robin scheduler and the dout consumer.
// Handshake: a beat transfers on each rising edge where gnt_valid=1 and ack=1; ack is ignored while gnt_valid=0.
interface mux8x1_rr_sched_if #(
    parameter int NUM_REQ = 8,
    parameter int SEL_W   = 3,
    parameter int HOLD_W  = 4
);
    logic [NUM_REQ-1:0] req;
    logic [HOLD_W-1:0]  hold_len;
    logic               ack;
    logic [SEL_W-1:0]   sel;
    logic [NUM_REQ-1:0] grant;
    logic               gnt_valid;
    logic               last;
    logic               dbg_state;

    // Requesters and consumer side.
    modport master (
        output req, hold_len, ack,
        input  sel, grant, gnt_valid, last, dbg_state
    );

    // Scheduler side.
    modport slave (
        input  req, hold_len, ack,
        output sel, grant, gnt_valid, last, dbg_state
    );
endinterface

// File: rtl/mux8x1_rr_sched.sv
// Round-robin scheduler driving the select of an 8:1 bit mux; each grant lasts hold_len+1 acked beats
// or until the owner drops its request, after which priority rotates past the owner.
module mux8x1_rr_sched #(
    parameter int NUM_REQ = 8,
    parameter int SEL_W   = 3,
    parameter int HOLD_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux8x1_rr_sched_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               gv_q, gv_d;

    logic               rel;
    logic [NUM_REQ-1:0] others;
    logic [SEL_W-1:0]   win;

    // First set bit of r scanning base, base+1, ... with wrap; the descending loop lets the
    // smallest offset from base overwrite any later candidate.
    function automatic logic [SEL_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                              input logic [SEL_W-1:0]   base);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] res;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = base + i[SEL_W-1:0];
            if (r[idx]) res = idx;
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            gv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        gv_d    = gv_q;
        rel     = 1'b0;
        win     = '0;
        others  = bus.req & ~grant_q;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    win     = pick(bus.req, ptr_q);
                    sel_d   = win;
                    grant_d = onehot(win);
                    gv_d    = 1'b1;
                    cnt_d   = bus.hold_len;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Release wins over counting; an owner dropping req ends the burst without ack.
                rel = (bus.ack && (cnt_q == '0)) || !bus.req[sel_q];
                if (rel) begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (|others) begin
                        // Scanning from sel+1 over the full req reaches the old owner last,
                        // so with another requester present the winner is never the old owner.
                        win     = pick(bus.req, sel_q + SEL_W'(1));
                        sel_d   = win;
                        grant_d = onehot(win);
                        cnt_d   = bus.hold_len;
                    end else begin
                        grant_d = '0;
                        gv_d    = 1'b0;
                        state_d = IDLE;
                    end
                end else if (bus.ack) begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.gnt_valid = gv_q;
    assign bus.last      = gv_q && (cnt_q == '0);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mux8x1_rr_sched.sv
// Directed bench for mux8x1_rr_sched: inputs change and outputs are checked on the falling edge.
module tb_mux8x1_rr_sched;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux8x1_rr_sched_if #(.NUM_REQ(8), .SEL_W(3), .HOLD_W(4)) bus ();

    mux8x1_rr_sched #(.NUM_REQ(8), .SEL_W(3), .HOLD_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [2:0] e_sel, input logic [7:0] e_grant,
                           input logic e_gv, input logic e_last);
        chk({tag, ".sel"},       32'(bus.sel),       32'(e_sel));
        chk({tag, ".grant"},     32'(bus.grant),     32'(e_grant));
        chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(e_gv));
        chk({tag, ".last"},      32'(bus.last),      32'(e_last));
    endtask

    initial begin
        logic [2:0] e_sel;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.req      = 8'hFF;
        bus.hold_len = 4'd0;
        bus.ack      = 1'b0;

        // Reset held with all lanes requesting.
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 3'd0, 8'h00, 1'b0, 1'b0);
        chk("reset.state", 32'(bus.dbg_state), 32'd0);

        rst_n   = 1'b1;
        bus.req = 8'h00;
        bus.ack = 1'b1;
        step();
        chk_out("idle_ack", 3'd0, 8'h00, 1'b0, 1'b0);

        // Full rotation, hold_len=0, ack tied high: no bubbles.
        bus.req      = 8'hFF;
        bus.hold_len = 4'd0;
        for (int i = 0; i < 9; i++) begin
            step();
            e_sel = 3'(i);
            chk($sformatf("rot%0d.sel", i), 32'(bus.sel), 32'(e_sel));
            chk($sformatf("rot%0d.gv", i), 32'(bus.gnt_valid), 32'd1);
        end
        chk("rot8.grant", 32'(bus.grant), 32'h01);
        bus.req = 8'h00;
        step();
        chk_out("rot_end", 3'd0, 8'h00, 1'b0, 1'b0);
        chk("rot_end.state", 32'(bus.dbg_state), 32'd0);

        // Single lane 5, hold_len=2: three beats, last on the third, sel kept after release.
        bus.req      = 8'b0010_0000;
        bus.hold_len = 4'd2;
        bus.ack      = 1'b1;
        step();
        chk_out("single.b1", 3'd5, 8'h20, 1'b1, 1'b0);
        chk("single.state", 32'(bus.dbg_state), 32'd1);
        step();
        chk_out("single.b2", 3'd5, 8'h20, 1'b1, 1'b0);
        step();
        chk_out("single.b3", 3'd5, 8'h20, 1'b1, 1'b1);
        step();
        chk_out("single.done", 3'd5, 8'h00, 1'b0, 1'b0);
        bus.req = 8'h00;

        // Pointer wrap: lane 6 burst, then lanes 6 and 0 requesting -> lane 0 before lane 6.
        bus.req      = 8'b0100_0000;
        bus.hold_len = 4'd0;
        step();
        chk_out("wrap.l6", 3'd6, 8'h40, 1'b1, 1'b1);
        bus.req = 8'b0100_0001;
        step();
        chk_out("wrap.l0", 3'd0, 8'h01, 1'b1, 1'b1);
        step();
        chk_out("wrap.l6b", 3'd6, 8'h40, 1'b1, 1'b1);
        bus.req = 8'h00;
        step();
        chk_out("wrap.idle", 3'd6, 8'h00, 1'b0, 1'b0);

        // Owner drop: lane 3 with hold_len=7; hold_len change mid-burst must be ignored.
        bus.req      = 8'b0000_1000;
        bus.hold_len = 4'd7;
        bus.ack      = 1'b1;
        step();
        chk_out("drop.grant", 3'd3, 8'h08, 1'b1, 1'b0);
        bus.hold_len = 4'd0;
        step();
        chk_out("drop.ack1", 3'd3, 8'h08, 1'b1, 1'b0);
        step();
        chk_out("drop.ack2", 3'd3, 8'h08, 1'b1, 1'b0);
        bus.req      = 8'b0000_0010;
        bus.hold_len = 4'd1;
        step();
        chk_out("drop.l1", 3'd1, 8'h02, 1'b1, 1'b0);
        step();
        chk_out("drop.l1last", 3'd1, 8'h02, 1'b1, 1'b1);
        bus.req = 8'h00;
        step();
        chk_out("drop.idle", 3'd1, 8'h00, 1'b0, 1'b0);

        // Ack stall on lane 2, hold_len=1, ack pattern 0,0,1,0,1.
        bus.req      = 8'b0000_0100;
        bus.hold_len = 4'd1;
        bus.ack      = 1'b0;
        step();
        chk_out("stall.c1", 3'd2, 8'h04, 1'b1, 1'b0);
        step();
        chk_out("stall.c2", 3'd2, 8'h04, 1'b1, 1'b0);
        bus.ack = 1'b1;
        step();
        chk_out("stall.c3", 3'd2, 8'h04, 1'b1, 1'b1);
        bus.ack = 1'b0;
        step();
        chk_out("stall.c4", 3'd2, 8'h04, 1'b1, 1'b1);
        bus.ack = 1'b1;
        step();
        // Lane 2 still requests alone: one idle cycle, then re-granted.
        chk_out("stall.rel", 3'd2, 8'h00, 1'b0, 1'b0);
        bus.hold_len = 4'd7;
        step();
        chk_out("regrant", 3'd2, 8'h04, 1'b1, 1'b0);

        // Asynchronous reset mid-burst, checked before the next rising edge.
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 3'd0, 8'h00, 1'b0, 1'b0);
        chk("async_rst.state", 32'(bus.dbg_state), 32'd0);
        bus.req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_out("post_rst", 3'd0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
